ppc_ram_req_sched: RTL

- Request scheduler directly upstream of the 64x8 dual-port true-write RAM.
- Accepts a single in-order stream of byte load/store requests over a valid/ready handshake and buffers them in a small FIFO.
- Dual-issues the two oldest requests per cycle onto RAM ports A and B. Holds back port B on a same-address hazard.
- Returns read data to the requester in program order on two response lanes.

---
 rtl/ppc_ram_pkg.sv | 16 +
 rtl/ppc_req_fifo.sv | 45 ++++
 rtl/ppc_ram_req_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/ppc_ram_pkg.sv
// Shared defaults and request layout for the 64x8 RAM scheduler, its RAM and the upstream LSU.
package ppc_ram_pkg;

  localparam int unsigned RAM_AW    = 6;
  localparam int unsigned RAM_DW    = 8;
  localparam int unsigned REQ_DEPTH = 4;

  typedef struct packed {
    logic              we;
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] data;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

endpackage

// File: rtl/ppc_req_fifo.sv
// Request FIFO with one push and a 0..2 pop port; exposes the two oldest entries.
module ppc_req_fifo
  import ppc_ram_pkg::*;
#(
  parameter int unsigned W     = REQ_W,
  parameter int unsigned DEPTH = REQ_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic [1:0]    pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head,
  output logic [W-1:0]  head1
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + PW'(1)];

endmodule

// File: rtl/ppc_ram_req_sched.sv
// Dual-issue load/store scheduler in front of the dual-port RAM; returns loads in order.
module ppc_ram_req_sched
  import ppc_ram_pkg::*;
#(
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DW    = RAM_DW,
  parameter int unsigned DEPTH = REQ_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_enw_a,
  output logic          ram_enw_b,
  input  logic [DW-1:0] ram_q_a,
  input  logic [DW-1:0] ram_q_b,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [CW-1:0] count
);

  localparam int unsigned RW = 1 + AW + DW;

  logic [RW-1:0] head, head1;
  logic          push, issue_a, issue_b, hazard;
  logic [1:0]    pop;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          pend_a_q, pend_b_q, order_ab_q;

  ppc_req_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data ({req_we, req_addr, req_data}),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .head1     (head1)
  );

  assign {we0, addr0, data0} = head;
  assign {we1, addr1, data1} = head1;

  // Readiness looks only at the registered count, so a full FIFO refuses even while popping.
  assign req_ready = count < CW'(DEPTH);
  assign push      = req_valid & req_ready;

  assign hazard  = (addr0 == addr1) && (we0 || we1);
  assign issue_a = count != '0;
  assign issue_b = (count >= CW'(2)) && !hazard;
  assign pop     = {1'b0, issue_a} + {1'b0, issue_b};

  always_comb begin
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_enw_a  = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_enw_b  = 1'b0;
    if (issue_a) begin
      ram_addr_a = addr0;
      ram_data_a = data0;
      ram_enw_a  = we0;
    end
    if (issue_b) begin
      ram_addr_b = addr1;
      ram_data_b = data1;
      ram_enw_b  = we1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      order_ab_q <= 1'b0;
    end else begin
      pend_a_q   <= issue_a & ~we0;
      pend_b_q   <= issue_b & ~we1;
      order_ab_q <= 1'b1;
    end
  end

  // Compact pending reads onto the lanes so rsp0 always carries the oldest load.
  always_comb begin
    rsp0_valid = pend_a_q | pend_b_q;
    rsp1_valid = pend_a_q & pend_b_q;
    rsp1_data  = '0;
    if (pend_a_q && pend_b_q) begin
      rsp0_data = order_ab_q ? ram_q_a : ram_q_b;
      rsp1_data = order_ab_q ? ram_q_b : ram_q_a;
    end else if (pend_a_q) begin
      rsp0_data = ram_q_a;
    end else begin
      rsp0_data = ram_q_b;
    end
  end

endmodule
